jk_updown_counter: RTL
======================

JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

Interface
REQ-001 The module SHALL have parameter MODULO, default 10, giving the count range 0..MODULO-1; the legal values are 2..16.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port enable, input, 1 bit: count enable.
REQ-005 The module SHALL have port up, input, 1 bit: 1 counts up, 0 counts down.
REQ-006 The module SHALL have port load, input, 1 bit: synchronous parallel load request.
REQ-007 The module SHALL have port D, input, 4 bits: the parallel load value.
REQ-008 The module SHALL have port Q, output, 4 bits: the current count.
REQ-009 The module SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-010 The module SHALL have port wrap, output, 1 bit: registered one-cycle pulse following a wrap.

Function
REQ-011 Each bit of Q SHALL be stored in its own JK flip-flop cell; the next-state logic SHALL drive only the J and K inputs of each cell.
REQ-012 Excitation SHALL be as follows: a toggle sets J=K=1, a hold sets J=K=0, a load sets J=D[i] and K=~D[i].
REQ-013 Actions SHALL be prioritized per edge: load first, then enable counting, then hold.
REQ-014 Load SHALL take effect without enable; on the next edge Q=D.
REQ-015 If a load has D>=MODULO, Q SHALL take MODULO-1 (clamp).
REQ-016 With enable=1, up=1, load=0 the count SHALL be Q+1; from MODULO-1 the count SHALL wrap to 0.
REQ-017 With enable=1, up=0, load=0 the count SHALL be Q-1; from 0 the count SHALL wrap to MODULO-1.
REQ-018 Each count step SHALL take 1 cycle of latency, edge to Q.
REQ-019 tc SHALL equal enable & ~load & (up ? Q==MODULO-1 : Q==0).
REQ-020 wrap SHALL be 1 for exactly the cycle after an edge on which a wrap occurred, and 0 otherwise; a load SHALL never assert wrap.
REQ-021 A change of up between edges SHALL affect only the next edge; there SHALL be no glitch state on Q.
REQ-022 With MODULO=16 the count SHALL follow natural 4-bit wrap, and the clamp SHALL never apply.

Reset
REQ-023 reset=0 SHALL force Q=0 and wrap=0 immediately, independent of clk.
REQ-024 Reset asserted mid-count or mid-load SHALL abort the operation; no pending load SHALL survive.
REQ-025 On the first edge after reset deasserts, the normal rules SHALL apply (up=1, enable=1 gives Q=1).

Configuration
REQ-026 Macro JK_COUNTER_SATURATE_EN SHALL select saturation in place of wrap.
REQ-027 With JK_COUNTER_SATURATE_EN defined, up at MODULO-1 SHALL hold, down at 0 SHALL hold, and wrap SHALL be tied to 0.
REQ-028 With JK_COUNTER_SATURATE_EN undefined, the wrap behaviour of REQ-016, REQ-017 and REQ-020 SHALL apply.
REQ-029 tc SHALL be identical in both builds.

Verification
REQ-030 Bench SHALL check reset: MODULO=10, reset=0 with Q=7 and clk stopped -> Q=0 and wrap=0 at once.
REQ-031 Bench SHALL check up wrap: MODULO=10, enable=1, up=1, 12 edges from 0 -> Q sequence 1..9,0,1,2; tc=1 while Q=9; wrap=1 only in the cycle after 9->0.
REQ-032 Bench SHALL check down wrap: MODULO=10, up=0 from Q=1 -> 0 then 9; wrap pulses once.
REQ-033 Bench SHALL check load and clamp: enable=0, load=1, D=4 -> Q=4; load=1, D=13 -> Q=9; load=1 and enable=1 together, D=2 -> Q=2 with no count applied.
REQ-034 Bench SHALL check the saturate build: JK_COUNTER_SATURATE_EN defined, Q=9, up=1, 3 edges -> Q stays 9 and wrap stays 0.
REQ-035 Bench SHALL check MODULO=16: Q=15, up=1 -> Q=0 and wrap=1; load with D=15 -> Q=15 with no clamp.

Source files
------------

// File: rtl/jk_updown_counter.sv
// Modulo-N up/down counter built from per-bit JK flip-flops, with parallel load (clamped to MODULO-1).
// Build option JK_COUNTER_SATURATE_EN: hold at the range ends instead of wrapping (wrap output tied low).

module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end
endmodule

module jk_updown_counter #(
  parameter int MODULO = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       tc,
  output logic       wrap
);
  localparam logic [3:0] QMAX = 4'(MODULO - 1);

  logic       at_end;
  logic       count;
  logic [3:0] ld_val;
  logic [3:0] nxt;
  logic [3:0] j;
  logic [3:0] k;

  assign at_end = up ? (Q == QMAX) : (Q == 4'd0);
  assign count  = enable & ~load;
  assign tc     = count & at_end;

  always_comb begin
    ld_val = D;
    if ({1'b0, D} >= 5'(MODULO)) ld_val = QMAX;
  end

  always_comb begin
    nxt = up ? (Q + 4'd1) : (Q - 4'd1);
    if (at_end) begin
`ifdef JK_COUNTER_SATURATE_EN
      nxt = Q;
`else
      nxt = up ? 4'd0 : QMAX;
`endif
    end
  end

  // Count steps toggle exactly the bits that differ; loads force each bit via J/K.
  always_comb begin
    j = 4'd0;
    k = 4'd0;
    if (load) begin
      j = ld_val;
      k = ~ld_val;
    end else if (enable) begin
      j = Q ^ nxt;
      k = Q ^ nxt;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_bit
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j[i]),
      .k     (k[i]),
      .q     (Q[i])
    );
  end

`ifdef JK_COUNTER_SATURATE_EN
  assign wrap = 1'b0;
`else
  logic wrap_q;

  // A counting edge taken at the terminal count is exactly a wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wrap_q <= 1'b0;
    else        wrap_q <= tc;
  end

  assign wrap = wrap_q;
`endif
endmodule
